// File: rtl/mdio_pkg.sv
// mdio_pkg: shared types and constants for the Clause-22 MDIO slave.
// Holds the frame FSM state encoding, the opcode and start-of-frame
// patterns, and the field widths used by mdio_slave_if.
package mdio_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_OPCODE,
    ST_PHYAD,
    ST_REGAD,
    ST_TA,
    ST_WDATA,
    ST_RDATA
  } mdio_state_e;

  localparam logic [1:0] OP_WRITE  = 2'b01;
  localparam logic [1:0] OP_READ   = 2'b10;
  localparam logic [1:0] START_PAT = 2'b01;

  localparam int PHYAD_W = 5;
  localparam int REGAD_W = 5;
  localparam int DATA_W  = 16;

endpackage

// File: rtl/mdio_sync_edge.sv
// mdio_sync_edge: brings the asynchronous MDC/MDIO pad signals into the
// clk domain and produces a one-cycle pulse on each MDC rising edge.
// Ports:
//   clk        - system clock
//   rst_n      - asynchronous active-low reset
//   mdc_i      - raw MDC from the pad
//   mdio_i     - raw MDIO from the pad
//   mdio_o     - synchronized MDIO level
//   mdc_rise_o - one clk pulse per synchronized MDC 0->1 transition
module mdio_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic mdc_i,
  input  logic mdio_i,
  output logic mdio_o,
  output logic mdc_rise_o
);

  // mdc_q[1:0] is the 2-flop synchronizer, mdc_q[2] the previous
  // synchronized level used for edge detection.
  logic [2:0] mdc_q;
  logic [1:0] mdio_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdc_q  <= '0;
      mdio_q <= '0;
    end else begin
      mdc_q  <= {mdc_q[1:0], mdc_i};
      mdio_q <= {mdio_q[0], mdio_i};
    end
  end

  assign mdio_o     = mdio_q[1];
  assign mdc_rise_o = mdc_q[1] & ~mdc_q[2];

endmodule

// File: rtl/mdio_slave_if.sv
// mdio_slave_if: Clause-22 MDIO management slave in front of a PHY
// register file. Decodes frames sampled on MDC rising edges; writes
// become a one-clk ADDR/WR_DATA/WR_STB transaction, reads capture
// RD_DATA and shift it back out on MDIO.
// Ports:
//   clk      - system clock (>= 4x MDC)
//   reset    - asynchronous active-low reset
//   MDC      - management clock (async to clk)
//   MDIO_IN  - MDIO as seen at the pad
//   MDIO_OUT - value driven onto MDIO while MDIO_OE=1
//   MDIO_OE  - MDIO tristate enable (1 = slave drives)
//   ADDR     - register address to the register file
//   WR_DATA  - write data to the register file
//   WR_STB   - one-clk write strobe
//   RD_DATA  - combinational read data for the current ADDR
module mdio_slave_if
  import mdio_pkg::*;
#(
  parameter logic [4:0] PHY_ADDR     = 5'd0,
  parameter int         PREAMBLE_LEN = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                MDC,
  input  logic                MDIO_IN,
  output logic                MDIO_OUT,
  output logic                MDIO_OE,
  output logic [REGAD_W-1:0]  ADDR,
  output logic [DATA_W-1:0]   WR_DATA,
  output logic                WR_STB,
  input  logic [DATA_W-1:0]   RD_DATA
);

  logic mdio_s;
  logic mdc_rise;

  mdio_sync_edge u_sync (
    .clk        (clk),
    .rst_n      (reset),
    .mdc_i      (MDC),
    .mdio_i     (MDIO_IN),
    .mdio_o     (mdio_s),
    .mdc_rise_o (mdc_rise)
  );

  mdio_state_e         state_q, state_d;
  logic [4:0]          bit_cnt_q, bit_cnt_d;
  logic [5:0]          pre_cnt_q, pre_cnt_d;
  logic [1:0]          op_q, op_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [REGAD_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                wr_stb_q, wr_stb_d;
  logic                oe_q, oe_d;
  logic                out_q, out_d;

  // Field values as they complete on the current edge: the last bit is
  // still on mdio_s and has not been shifted in yet.
  logic [4:0] field5;
  logic [1:0] op_bits;
  logic       ta_ok;
  logic       pre_ok;

  assign field5  = {shift_q[3:0], mdio_s};
  assign op_bits = {op_q[0], mdio_s};
  assign ta_ok   = shift_q[0] & ~mdio_s;
  assign pre_ok  = int'(pre_cnt_q) >= PREAMBLE_LEN;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      pre_cnt_q <= '0;
      op_q      <= '0;
      shift_q   <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wr_stb_q  <= 1'b0;
      oe_q      <= 1'b0;
      out_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      pre_cnt_q <= pre_cnt_d;
      op_q      <= op_d;
      shift_q   <= shift_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wr_stb_q  <= wr_stb_d;
      oe_q      <= oe_d;
      out_q     <= out_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (mdc_rise) begin
      case (state_q)
        ST_IDLE:   if (mdio_s == START_PAT[1] && pre_ok) state_d = ST_START;
        ST_START:  state_d = (mdio_s == START_PAT[0]) ? ST_OPCODE : ST_IDLE;
        ST_OPCODE: if (bit_cnt_q == 5'd1)
                     state_d = (op_bits == OP_WRITE || op_bits == OP_READ) ? ST_PHYAD : ST_IDLE;
        ST_PHYAD:  if (bit_cnt_q == 5'd4)
                     state_d = (field5 == PHY_ADDR) ? ST_REGAD : ST_IDLE;
        ST_REGAD:  if (bit_cnt_q == 5'd4) state_d = ST_TA;
        ST_TA:     if (bit_cnt_q == 5'd1) begin
                     if (op_q == OP_READ) state_d = ST_RDATA;
                     else                 state_d = ta_ok ? ST_WDATA : ST_IDLE;
                   end
        ST_WDATA:  if (bit_cnt_q == 5'd15) state_d = ST_IDLE;
        ST_RDATA:  if (bit_cnt_q == 5'd16) state_d = ST_IDLE;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    bit_cnt_d = bit_cnt_q;
    pre_cnt_d = pre_cnt_q;
    op_d      = op_q;
    shift_d   = shift_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wr_stb_d  = 1'b0;
    oe_d      = oe_q;
    out_d     = out_q;
    if (mdc_rise) begin
      // One counter serves every field; it restarts whenever the state changes.
      bit_cnt_d = (state_d != state_q) ? 5'd0 : bit_cnt_q + 5'd1;
      case (state_q)
        ST_IDLE: begin
          if (mdio_s) begin
            if (pre_cnt_q != 6'h3F) pre_cnt_d = pre_cnt_q + 6'd1;
          end else if (!pre_ok) begin
            pre_cnt_d = '0;
          end
        end
        ST_START:  pre_cnt_d = '0;
        ST_OPCODE: op_d = op_bits;
        ST_PHYAD:  shift_d = {shift_q[DATA_W-2:0], mdio_s};
        ST_REGAD: begin
          shift_d = {shift_q[DATA_W-2:0], mdio_s};
          if (bit_cnt_q == 5'd4) addr_d = field5;
        end
        ST_TA: begin
          if (op_q == OP_READ) begin
            // First TA edge captures the register; second starts driving the TA zero.
            if (bit_cnt_q == 5'd0) begin
              shift_d = RD_DATA;
            end else begin
              oe_d  = 1'b1;
              out_d = 1'b0;
            end
          end else begin
            shift_d = {shift_q[DATA_W-2:0], mdio_s};
          end
        end
        ST_WDATA: begin
          shift_d = {shift_q[DATA_W-2:0], mdio_s};
          if (bit_cnt_q == 5'd15) begin
            wdata_d  = {shift_q[DATA_W-2:0], mdio_s};
            wr_stb_d = 1'b1;
          end
        end
        ST_RDATA: begin
          if (bit_cnt_q == 5'd16) begin
            oe_d  = 1'b0;
            out_d = 1'b0;
          end else begin
            out_d   = shift_q[DATA_W-1];
            shift_d = {shift_q[DATA_W-2:0], 1'b0};
          end
        end
        default: ;
      endcase
    end
  end

  assign ADDR     = addr_q;
  assign WR_DATA  = wdata_q;
  assign WR_STB   = wr_stb_q;
  assign MDIO_OE  = oe_q;
  assign MDIO_OUT = out_q;

endmodule
